// File: rtl/mux_nto1_arb.sv
// N-to-1 registered multiplexer with valid/ready handshakes.
// Selection is either a fixed channel (MODE=0) or round-robin (MODE=1).
module mux_nto1_arb #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  input  logic [CHANNELS-1:0]       IN_VALID,
  output logic [CHANNELS-1:0]       IN_READY,
  input  logic                      MODE,
  input  logic [SEL_W-1:0]          S0,
  output logic [WIDTH-1:0]          Z,
  output logic                      Z_VALID,
  input  logic                      Z_READY,
  output logic [SEL_W-1:0]          Z_CH
);

  logic [SEL_W-1:0]      ptr;
  logic [SEL_W-1:0]      grantIdx;
  logic                  grantHit;
  logic                  loadOk;
  logic                  inXfer;
  logic [WIDTH-1:0]      grantData;
  logic [2*CHANNELS-1:0] validDbl;
  logic [CHANNELS-1:0]   rotValid;
  int                    rrOff;
  int                    rrIdx;

  assign loadOk = !Z_VALID || Z_READY;

  // rotValid bit k stands for channel (ptr+1+k) mod CHANNELS, so the lowest set bit wins.
  always_comb begin
    validDbl = {IN_VALID, IN_VALID};
    rotValid = CHANNELS'(validDbl >> (int'(ptr) + 1));
    rrOff    = 0;
    rrIdx    = 0;
    grantHit = 1'b0;
    grantIdx = '0;
    if (!MODE) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(S0) == i && IN_VALID[i]) begin
          grantHit = 1'b1;
          grantIdx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (rotValid[k]) begin
          grantHit = 1'b1;
          rrOff    = k;
        end
      end
      rrIdx = int'(ptr) + 1 + rrOff;
      if (rrIdx >= CHANNELS) rrIdx = rrIdx - CHANNELS;
      grantIdx = SEL_W'(rrIdx);
    end
  end

  always_comb begin
    grantData = '0;
    IN_READY  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(grantIdx) == i) begin
        grantData   = IN_DATA[i*WIDTH +: WIDTH];
        IN_READY[i] = RST_N && loadOk && grantHit;
      end
    end
  end

  assign inXfer = |IN_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Z       <= '0;
      Z_VALID <= 1'b0;
      Z_CH    <= '0;
      ptr     <= SEL_W'(CHANNELS - 1);
    end else if (inXfer) begin
      Z       <= grantData;
      Z_CH    <= grantIdx;
      Z_VALID <= 1'b1;
      if (MODE) ptr <= grantIdx;
    end else if (Z_READY) begin
      Z_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Randomized and directed bench for mux_nto1_arb; a 4-channel and a 3-channel
// instance run in lockstep against a behavioural handshake model.
module tb_mux_nto1_arb;
  localparam int W4 = 32;
  localparam int C4 = 4;
  localparam int W3 = 8;
  localparam int C3 = 3;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic MODE = 1'b0;
  logic [1:0] S0 = '0;
  logic zReady = 1'b0;
  logic [C4*W4-1:0] data4 = '0;
  logic [C4-1:0] valid4 = '0;
  logic [C3*W3-1:0] data3;
  logic [C3-1:0] valid3;
  logic [C4-1:0] ready4;
  logic [C3-1:0] ready3;
  logic [W4-1:0] z4;
  logic [W3-1:0] z3;
  logic zv4, zv3;
  logic [1:0] zch4, zch3;

  always #5 CLK = ~CLK;

  assign valid3 = valid4[C3-1:0];
  always_comb begin
    data3 = '0;
    for (int i = 0; i < C3; i++) data3[i*W3 +: W3] = data4[i*W4 +: W3];
  end

  mux_nto1_arb #(.WIDTH(W4), .CHANNELS(C4), .SEL_W(2)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .IN_DATA(data4), .IN_VALID(valid4), .IN_READY(ready4),
    .MODE(MODE), .S0(S0), .Z(z4), .Z_VALID(zv4), .Z_READY(zReady), .Z_CH(zch4));

  mux_nto1_arb #(.WIDTH(W3), .CHANNELS(C3), .SEL_W(2)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .IN_DATA(data3), .IN_VALID(valid3), .IN_READY(ready3),
    .MODE(MODE), .S0(S0), .Z(z3), .Z_VALID(zv3), .Z_READY(zReady), .Z_CH(zch3));

  // model state per instance: 0 = four channels, 1 = three channels
  int chans[2] = '{C4, C3};
  logic [31:0] mZ[2];
  bit mV[2];
  int mCh[2];
  int mPtr[2];
  int vectors = 0;
  int miscompares = 0;
  int rrZ[6] = '{1, 2, 3, 4, 1, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // search order for round robin is ptr+1, ptr+2, ... ptr (mod ch)
  function automatic int expGrant(input int d);
    int ch;
    ch = chans[d];
    if (!MODE) return (int'(S0) < ch && valid4[S0]) ? int'(S0) : -1;
    for (int k = 1; k <= ch; k++) begin
      if (valid4[(mPtr[d] + k) % ch]) return (mPtr[d] + k) % ch;
    end
    return -1;
  endfunction

  function automatic logic [31:0] chData(input int d, input int c);
    return (d == 0) ? data4[c*W4 +: W4] : {24'b0, data4[c*W4 +: W3]};
  endfunction

  function automatic logic [31:0] expReady(input int d);
    int g;
    g = expGrant(d);
    if (RST_N && (!mV[d] || zReady) && g >= 0) return 32'(1) << g;
    return 32'(0);
  endfunction

  task automatic checkOuts(input string tag);
    chk({tag, "_z4"}, z4, mZ[0]);
    chk({tag, "_zv4"}, 32'(zv4), 32'(mV[0]));
    chk({tag, "_zch4"}, 32'(zch4), 32'(mCh[0]));
    chk({tag, "_z3"}, 32'(z3), mZ[1]);
    chk({tag, "_zv3"}, 32'(zv3), 32'(mV[1]));
    chk({tag, "_zch3"}, 32'(zch3), 32'(mCh[1]));
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mZ[d] = '0;
      mV[d] = 1'b0;
      mCh[d] = 0;
      mPtr[d] = chans[d] - 1;
    end
  endtask

  // one clock: check ready against current inputs, then registered outputs after the edge
  task automatic cycle(input string tag);
    int g[2];
    bit xfer[2];
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d] = expGrant(d);
      xfer[d] = (expReady(d) != 0);
    end
    chk({tag, "_rdy4"}, 32'(ready4), expReady(0));
    chk({tag, "_rdy3"}, 32'(ready3), expReady(1));
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (xfer[d]) begin
        mZ[d] = chData(d, g[d]);
        mCh[d] = g[d];
        mV[d] = 1'b1;
        if (MODE) mPtr[d] = g[d];
      end else if (zReady) begin
        mV[d] = 1'b0;
      end
    end
    #1;
    checkOuts(tag);
  endtask

  // asynchronous pulse placed between clock edges
  task automatic pulseReset();
    #2 RST_N = 1'b0;
    #1;
    modelReset();
    checkOuts("rst");
    chk("rst_rdy4", 32'(ready4), 32'(0));
    chk("rst_rdy3", 32'(ready3), 32'(0));
    #1 RST_N = 1'b1;
  endtask

  task automatic setData(input int a, input int b, input int c, input int e);
    data4 = {32'(e), 32'(c), 32'(b), 32'(a)};
  endtask

  initial begin
    modelReset();
    valid4 = 4'b1111;
    setData(7, 8, 9, 10);
    @(posedge CLK);
    #1;
    checkOuts("init");
    chk("init_rdy4", 32'(ready4), 32'(0));
    #3 RST_N = 1'b1;

    // fixed select
    MODE = 1'b0; zReady = 1'b1; setData(10, 20, 30, 40); valid4 = 4'b1111; S0 = 2'd0;
    #1 chk("fix_rdy0", 32'(ready4), 32'b0001);
    cycle("fix0");
    chk("fix_z0", z4, 32'd10);
    chk("fix_ch0", 32'(zch4), 32'd0);
    S0 = 2'd1;
    #1 chk("fix_rdy1", 32'(ready4), 32'b0010);
    cycle("fix1");
    chk("fix_z1", z4, 32'd20);
    chk("fix_ch1", 32'(zch4), 32'd1);

    // round-robin fairness from reset
    pulseReset();
    MODE = 1'b1; zReady = 1'b1; setData(1, 2, 3, 4); valid4 = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      cycle("rr");
      chk("rr_z", z4, 32'(rrZ[k]));
      chk("rr_ch", 32'(zch4), 32'(k % 4));
    end

    // backpressure holds the word
    MODE = 1'b0; S0 = 2'd1; setData(10, 20, 30, 40); zReady = 1'b1;
    cycle("bp_load");
    chk("bp_z", z4, 32'd20);
    zReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setData($urandom, $urandom, $urandom, $urandom);
      cycle("bp_hold");
      chk("bp_hold_z", z4, 32'd20);
      chk("bp_hold_rdy", 32'(ready4), 32'd0);
    end
    setData(11, 55, 33, 44); zReady = 1'b1;
    cycle("bp_rel");
    chk("bp_rel_z", z4, 32'd55);

    // round-robin skip
    pulseReset();
    MODE = 1'b1; zReady = 1'b1; setData(1, 2, 3, 4);
    valid4 = 4'b0001; cycle("skip_p0");
    valid4 = 4'b1000; cycle("skip_c3");
    chk("skip_ch3", 32'(zch4), 32'd3);
    valid4 = 4'b0101; cycle("skip_c0");
    chk("skip_ch0", 32'(zch4), 32'd0);

    // reset mid-operation
    MODE = 1'b0; S0 = 2'd1; setData(10, 20, 30, 40); valid4 = 4'b1111; zReady = 1'b1;
    cycle("mid_load");
    zReady = 1'b0;
    pulseReset();
    chk("mid_z", z4, 32'd0);
    chk("mid_zv", 32'(zv4), 32'd0);
    MODE = 1'b1; valid4 = 4'b0110; zReady = 1'b1;
    cycle("mid_rr");
    chk("mid_rr_ch", 32'(zch4), 32'd1);

    // select beyond the channel count on the 3-channel instance
    pulseReset();
    MODE = 1'b0; S0 = 2'd3; valid4 = 4'b1111; zReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle("inv");
      chk("inv_rdy3", 32'(ready3), 32'd0);
      chk("inv_zv3", 32'(zv3), 32'd0);
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) pulseReset();
      MODE = 1'($urandom_range(0, 1));
      S0 = 2'($urandom_range(0, 3));
      valid4 = 4'($urandom);
      setData($urandom, $urandom, $urandom, $urandom);
      zReady = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux_nto1_arb.md
MUX_NTO1_ARB -- requirements
Module: mux_nto1_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width per channel in bits.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of input channels, legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default 2, meaning select/channel-index width, equal to ceil(log2(CHANNELS)).
REQ-004 SHALL have CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have IN_DATA  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have IN_VALID  input  CHANNELS  per-channel valid.
REQ-008 SHALL have IN_READY  output  CHANNELS  per-channel ready (combinational).
REQ-009 SHALL have MODE  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-010 SHALL have S0  input  SEL_W  channel select, used only when MODE = 0.
REQ-011 SHALL have Z  output  WIDTH  registered output data.
REQ-012 SHALL have Z_VALID  output  1  Z holds an untaken word.
REQ-013 SHALL have Z_READY  input  1  downstream accepts Z.
REQ-014 SHALL have Z_CH  output  SEL_W  index of the channel that supplied Z.

Function
REQ-015 An input transfer on channel i SHALL occur on a rising edge where IN_VALID[i] and IN_READY[i] are both 1; an output transfer SHALL occur where Z_VALID and Z_READY are both 1.
REQ-016 The output register SHALL be loadable (LOAD_OK = 1) when Z_VALID = 0 or Z_READY = 1.
REQ-017 MODE = 0: grant SHALL be channel S0 if S0 < CHANNELS and IN_VALID[S0] = 1; otherwise no grant.
REQ-018 MODE = 1: grant SHALL be the first channel with IN_VALID = 1 searching PTR+1, PTR+2, ... modulo CHANNELS, ending with PTR itself; no grant if no IN_VALID bit is set.
REQ-019 IN_READY[i] SHALL be 1 only when LOAD_OK = 1 and channel i is granted; at most one IN_READY bit SHALL be 1 in any cycle.
REQ-020 On an input transfer, Z, Z_CH and Z_VALID SHALL be loaded on that edge with the granted data, the granted index and 1 respectively: latency one cycle.
REQ-021 On an output transfer with no simultaneous input transfer, Z_VALID SHALL clear to 0; Z and Z_CH SHALL keep their values.
REQ-022 A simultaneous output transfer and input transfer SHALL replace the word with no bubble, sustaining one word per cycle.
REQ-023 While Z_VALID = 1 and Z_READY = 0, Z and Z_CH SHALL be stable regardless of IN_*, MODE or S0 changes.
REQ-024 PTR (SEL_W bits) SHALL update to the granted index on every input transfer in MODE = 1 and SHALL be unchanged otherwise, including all MODE = 0 transfers.
REQ-025 MODE and S0 changes SHALL affect the grant combinationally in the same cycle; no drain or flush is required.
REQ-026 IN_VALID deasserting without a transfer SHALL NOT alter any state.

Reset
REQ-027 RST_N = 0 SHALL immediately, independent of CLK, force Z = 0, Z_VALID = 0, Z_CH = 0 and PTR = CHANNELS-1, so that the first round-robin search starts at channel 0.
REQ-028 While RST_N = 0, IN_READY SHALL be all zeros. Reset asserted mid-transfer SHALL discard the held word.
REQ-029 The first rising edge after RST_N returns to 1 SHALL operate normally.

Verification
REQ-030 Fixed select: MODE = 0, ch0 = 10, ch1 = 20, all valid, Z_READY = 1, S0 = 0 then S0 = 1 -> Z = 10, Z_CH = 0 one cycle after the first edge, then Z = 20, Z_CH = 1; IN_READY = 0001 then 0010.
REQ-031 Round-robin fairness: MODE = 1, all four channels valid with data 1, 2, 3, 4, Z_READY = 1 for 6 cycles -> Z sequence 1, 2, 3, 4, 1, 2; Z_CH sequence 0, 1, 2, 3, 0, 1.
REQ-032 Backpressure: Z holds 20 with Z_VALID = 1 and Z_READY = 0 for 3 cycles while IN_DATA changes -> Z stays 20 and IN_READY = 0000; Z_READY = 1 -> next word loads on the same edge.
REQ-033 Round-robin skip: MODE = 1, PTR = 0, only ch3 valid -> ch3 granted, PTR = 3; then ch0 and ch2 valid -> ch0 granted.
REQ-034 Reset mid-operation: Z_VALID = 1, Z = 20, RST_N pulsed low between clock edges -> Z = 0, Z_VALID = 0 immediately; first round-robin grant after release is the lowest valid channel.
REQ-035 Invalid select: CHANNELS = 3, MODE = 0, S0 = 3 -> IN_READY = 000 and Z_VALID stays 0.
